mips_reg_file: RTL
==================

Name: mips_reg_file

Overview:
- 32 x 32-bit MIPS general-purpose register file.
- Sits directly upstream of the ALU and its bitwise lanes (AND/OR/NOR/XOR).
- Supplies both operand buses combinationally and captures the writeback result on the clock edge.
- $zero is hardwired; optional same-cycle write-to-read bypass; one debug read port for testbench and trace.

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 5, register index width (2**ADDR_W registers).
- BYPASS, 1, 1 = a read of the register being written this cycle returns write_data; 0 = returns the old value.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- read_reg1  input  ADDR_W  rs index, operand 1.
- read_reg2  input  ADDR_W  rt index, operand 2.
- write_reg  input  ADDR_W  destination index (rd or rt, selected upstream).
- write_data  input  DATA_W  writeback value (ALU result or load data).
- reg_write  input  1  write enable.
- read_data1  output  DATA_W  operand 1 to ALU input1.
- read_data2  output  DATA_W  operand 2 to ALU input2 / ALUSrc mux.
- dbg_addr  input  ADDR_W  debug read index.
- dbg_data  output  DATA_W  debug read value, never bypassed.

Behaviour:
- Storage: 32 registers, each DATA_W bits. Register 0 has no storage: it always reads 0 and writes to it are discarded.
- Reset:
  - On a rising edge with reset=1, all 31 registers clear to 0.
  - Reset has priority over reg_write; a write in the reset cycle is lost.
  - Read outputs are combinational from the array, so they read 0 from the first post-reset cycle onward.
  - Reset asserted mid-program clears state at the next edge, with no partial write.
- Write:
  - On a rising edge with reset=0, reg_write=1 and write_reg!=0, register[write_reg] <= write_data.
  - With reg_write=0 no register changes; write_reg and write_data are ignored.
- Read (combinational, zero latency, any number of reads per cycle):
  - read_dataN = 0 if read_regN==0.
  - Otherwise, if BYPASS=1 and reg_write=1 and reset=0 and write_reg==read_regN, read_dataN = write_data.
  - Otherwise read_dataN = register[read_regN].
- Simultaneous events:
  - Both ports may read the same index; both return identical values.
  - Both ports may hit the bypass in the same cycle.
  - A write to index 0 never bypasses, so port output stays 0.
- dbg_data = register[dbg_addr] (0 for index 0), pre-write value, no bypass.
- No X propagation: every index is defined, so there are no out-of-range cases.
- Widths: all indices are ADDR_W bits and compared unsigned. No arithmetic is performed inside the block.

Decomposition:
- Shared package (mips_pkg):
  - DATA_W, ADDR_W, REG_ZERO=0.
  - Register index constants: REG_SP=29, REG_RA=31.
  - reg_idx_t and word_t typedefs, reused by decoder, ALU and writeback mux.
- One natural sub-module: mips_reg_read_port.
  - Contains the zero check, bypass compare and array mux.
  - Instantiated twice with bypass enabled (ports 1 and 2) and once with bypass forced off (debug port).
- The storage array and write/reset logic stay in the top module.

Test Plan:
- Reset then read all 32 indices on both ports and dbg -> every value 0x00000000.
- Write 0xDEADBEEF to r8, next cycle read_reg1=8, read_reg2=8 -> both 0xDEADBEEF; dbg_addr=8 -> 0xDEADBEEF.
- reg_write=1, write_reg=0, write_data=0xFFFFFFFF, read_reg1=0 -> read_data1=0 in that cycle and the next.
- BYPASS=1: r5 holds 0x11111111; in the same cycle write 0x22222222 to r5 with read_reg2=5 -> read_data2=0x22222222 before the edge, dbg_data=0x11111111. BYPASS=0 -> read_data2=0x11111111 until after the edge.
- Fill r1..r31 with 0xA5A50000|index, then assert reset together with reg_write=1 to r3=0x12345678 -> after the edge all registers read 0, including r3.
- Back-to-back writes: r31=0x0000FFFF then r31=0xFFFF0000 on consecutive cycles -> read_data1 follows each value one edge later (bypass off), r30 is unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath package.
// Holds the architectural widths, well-known register indices and the word and
// register-index types used by the decoder, ALU, writeback mux and register file.
package mips_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;

    // Architectural register indices
    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_SP   = 29;
    localparam int unsigned REG_RA   = 31;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/mips_reg_read_port.sv
// One combinational read port of the MIPS register file.
// Ports:
//   raddr    - register index to read
//   wr_en    - write of this cycle is live (reg_write and not reset)
//   wr_addr  - index being written this cycle
//   wr_data  - value being written this cycle
//   regs     - architectural view of all registers (entry 0 is constant 0)
//   rdata    - read result
// With BYPASS=1 a read of the index being written returns wr_data; index 0
// always reads 0 whether or not it is being written.
module mips_reg_read_port #(
    parameter int unsigned DATA_W = mips_pkg::DATA_W,
    parameter int unsigned ADDR_W = mips_pkg::ADDR_W,
    parameter bit          BYPASS = 1'b1
) (
    input  logic [ADDR_W-1:0] raddr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    output logic [DATA_W-1:0] rdata
);
    import mips_pkg::*;

    logic is_zero;
    logic bypass_hit;

    assign is_zero    = (raddr == ADDR_W'(REG_ZERO));
    assign bypass_hit = BYPASS && wr_en && (wr_addr == raddr);

    always_comb begin
        rdata = '0;
        if (is_zero) begin
            rdata = '0;
        end else if (bypass_hit) begin
            rdata = wr_data;
        end else begin
            rdata = regs[raddr];
        end
    end

endmodule

// File: rtl/mips_reg_file.sv
// 32 x 32-bit MIPS general-purpose register file.
// Ports:
//   clk         - clock, all state changes on the rising edge
//   reset       - synchronous active-high reset, clears r1..r31
//   read_reg1/2 - rs / rt operand indices
//   write_reg   - destination index
//   write_data  - writeback value
//   reg_write   - write enable
//   read_data1/2- combinational operands (optionally bypassed from the write port)
//   dbg_addr    - debug read index
//   dbg_data    - debug read value, always the stored (pre-write) value
// Register 0 has no storage; it reads 0 and writes to it are dropped.
module mips_reg_file #(
    parameter int unsigned DATA_W = mips_pkg::DATA_W,
    parameter int unsigned ADDR_W = mips_pkg::ADDR_W,
    parameter bit          BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    import mips_pkg::*;

    localparam int unsigned NREGS = 2**ADDR_W;

    // Physical storage only for r1..r(NREGS-1)
    logic [DATA_W-1:0] regs_q [1:NREGS-1];
    // Architectural view handed to the read ports, entry 0 tied to zero
    logic [DATA_W-1:0] rf_view [NREGS];
    logic              wr_live;

    // Reset wins over a same-cycle write, so the write is not live then
    assign wr_live = reg_write && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_write && (write_reg != ADDR_W'(REG_ZERO))) begin
            regs_q[write_reg] <= write_data;
        end
    end

    always_comb begin
        rf_view[0] = '0;
        for (int unsigned i = 1; i < NREGS; i++) begin
            rf_view[i] = regs_q[i];
        end
    end

    mips_reg_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port1 (
        .raddr   (read_reg1),
        .wr_en   (wr_live),
        .wr_addr (write_reg),
        .wr_data (write_data),
        .regs    (rf_view),
        .rdata   (read_data1)
    );

    mips_reg_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port2 (
        .raddr   (read_reg2),
        .wr_en   (wr_live),
        .wr_addr (write_reg),
        .wr_data (write_data),
        .regs    (rf_view),
        .rdata   (read_data2)
    );

    // Debug port shows committed state only, never the in-flight write
    mips_reg_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (1'b0)
    ) u_port_dbg (
        .raddr   (dbg_addr),
        .wr_en   (wr_live),
        .wr_addr (write_reg),
        .wr_data (write_data),
        .regs    (rf_view),
        .rdata   (dbg_data)
    );

endmodule
